// File: rtl/ysyx_23060077_trap_ctrl.sv
// rtl/ysyx_23060077_trap_ctrl.sv - trap/mret/timer-interrupt sequencer driving CSR writes and PC redirect (optional: YSYX_23060077_TRAP_VECTORED_EN)
module ysyx_23060077_trap_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int CSR_ADDR_WIDTH = 12
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      trap_valid_i,
   output logic                      trap_ready_o,
   input  logic                      exc_illegal_i,
   input  logic                      exc_ebreak_i,
   input  logic                      exc_ecall_i,
   input  logic                      mret_i,
   input  logic [DATA_WIDTH-1:0]     exc_pc_i,
   input  logic [DATA_WIDTH-1:0]     exc_tval_i,
   input  logic                      irq_timer_i,
   input  logic [DATA_WIDTH-1:0]     irq_pc_i,
   input  logic [DATA_WIDTH-1:0]     csr_mstatus_i,
   input  logic [DATA_WIDTH-1:0]     csr_mtvec_i,
   input  logic [DATA_WIDTH-1:0]     csr_mepc_i,
   output logic                      csr_wr_en_o,
   output logic [CSR_ADDR_WIDTH-1:0] csr_wr_addr_o,
   output logic [DATA_WIDTH-1:0]     csr_wr_data_o,
   output logic                      redirect_valid_o,
   output logic [DATA_WIDTH-1:0]     redirect_pc_o,
   input  logic                      redirect_ready_i,
   output logic                      busy_o
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      W_MEPC    = 3'd1,
      W_MCAUSE  = 3'd2,
      W_MTVAL   = 3'd3,
      W_MSTAT   = 3'd4,
      RET_MSTAT = 3'd5,
      REDIR     = 3'd6
   } state_t;

   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVAL   = CSR_ADDR_WIDTH'(12'h343);

   localparam logic [DATA_WIDTH-1:0] CAUSE_ILLEGAL = DATA_WIDTH'(2);
   localparam logic [DATA_WIDTH-1:0] CAUSE_EBREAK  = DATA_WIDTH'(3);
   localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL   = DATA_WIDTH'(11);
   localparam logic [DATA_WIDTH-1:0] CAUSE_MTIMER  = {1'b1, (DATA_WIDTH-1)'(7)};

   state_t state, state_next;

   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] cause_q;
   logic [DATA_WIDTH-1:0] tval_q;
   logic [DATA_WIDTH-1:0] target_q;

   logic                  exc_any;
   logic                  take_exc;
   logic                  take_mret;
   logic                  take_irq;
   logic [DATA_WIDTH-1:0] exc_cause;
   logic [DATA_WIDTH-1:0] mstatus_trap;
   logic [DATA_WIDTH-1:0] mstatus_ret;
   logic [DATA_WIDTH-1:0] vec_base;
   logic [DATA_WIDTH-1:0] trap_vector;

   // Event selection: exceptions outrank mret, and the interrupt is only
   // taken on a cycle where the EXU presents nothing.
   always_comb begin
      exc_any   = exc_illegal_i | exc_ebreak_i | exc_ecall_i;
      take_exc  = trap_valid_i & exc_any;
      take_mret = trap_valid_i & ~exc_any & mret_i;
      take_irq  = ~trap_valid_i & irq_timer_i & csr_mstatus_i[3];
      if (exc_illegal_i)
         exc_cause = CAUSE_ILLEGAL;
      else if (exc_ebreak_i)
         exc_cause = CAUSE_EBREAK;
      else
         exc_cause = CAUSE_ECALL;
   end

   // mstatus images for trap entry (stack MIE into MPIE) and mret (restore MIE).
   always_comb begin
      mstatus_trap        = csr_mstatus_i;
      mstatus_trap[7]     = csr_mstatus_i[3];
      mstatus_trap[3]     = 1'b0;
      mstatus_trap[12:11] = 2'b11;
      mstatus_ret         = csr_mstatus_i;
      mstatus_ret[3]      = csr_mstatus_i[7];
      mstatus_ret[7]      = 1'b1;
      mstatus_ret[12:11]  = 2'b11;
   end

   assign vec_base = {csr_mtvec_i[DATA_WIDTH-1:2], 2'b00};

`ifdef YSYX_23060077_TRAP_VECTORED_EN
   // Vectored mode offsets interrupts by 4*cause; exceptions stay on the base.
   logic unused_cause_bit;
   assign unused_cause_bit = cause_q[DATA_WIDTH-2];
   always_comb begin
      trap_vector = vec_base;
      if (csr_mtvec_i[1:0] == 2'b01 && cause_q[DATA_WIDTH-1])
         trap_vector = vec_base + {cause_q[DATA_WIDTH-3:0], 2'b00};
   end
`else
   // Mode bits are ignored: every trap lands on the base address.
   logic unused_mtvec_mode;
   assign unused_mtvec_mode = ^csr_mtvec_i[1:0];
   always_comb begin
      trap_vector = vec_base;
   end
`endif

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic: fixed CSR write walk, then hold in REDIR until the IFU takes it.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (take_exc)
               state_next = W_MEPC;
            else if (take_mret)
               state_next = RET_MSTAT;
            else if (take_irq)
               state_next = W_MEPC;
         end
         W_MEPC:    state_next = W_MCAUSE;
         W_MCAUSE:  state_next = W_MTVAL;
         W_MTVAL:   state_next = W_MSTAT;
         W_MSTAT:   state_next = REDIR;
         RET_MSTAT: state_next = REDIR;
         REDIR: begin
            if (redirect_ready_i)
               state_next = IDLE;
         end
         default:   state_next = IDLE;
      endcase
   end

   // Latched trap context and redirect target; the vector is sampled on REDIR entry.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q     <= '0;
         cause_q  <= '0;
         tval_q   <= '0;
         target_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take_exc) begin
                  pc_q    <= exc_pc_i;
                  cause_q <= exc_cause;
                  tval_q  <= exc_tval_i;
               end else if (take_mret) begin
                  target_q <= csr_mepc_i;
               end else if (take_irq) begin
                  pc_q    <= irq_pc_i;
                  cause_q <= CAUSE_MTIMER;
                  tval_q  <= '0;
               end
            end
            W_MSTAT: target_q <= trap_vector;
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; data buses are zero whenever their strobe is low.
   always_comb begin
      trap_ready_o     = 1'b0;
      busy_o           = 1'b1;
      csr_wr_en_o      = 1'b0;
      csr_wr_addr_o    = '0;
      csr_wr_data_o    = '0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      case (state)
         IDLE: begin
            trap_ready_o = 1'b1;
            busy_o       = 1'b0;
         end
         W_MEPC: begin
            csr_wr_en_o   = 1'b1;
            csr_wr_addr_o = ADDR_MEPC;
            csr_wr_data_o = pc_q;
         end
         W_MCAUSE: begin
            csr_wr_en_o   = 1'b1;
            csr_wr_addr_o = ADDR_MCAUSE;
            csr_wr_data_o = cause_q;
         end
         W_MTVAL: begin
            csr_wr_en_o   = 1'b1;
            csr_wr_addr_o = ADDR_MTVAL;
            csr_wr_data_o = tval_q;
         end
         W_MSTAT: begin
            csr_wr_en_o   = 1'b1;
            csr_wr_addr_o = ADDR_MSTATUS;
            csr_wr_data_o = mstatus_trap;
         end
         RET_MSTAT: begin
            csr_wr_en_o   = 1'b1;
            csr_wr_addr_o = ADDR_MSTATUS;
            csr_wr_data_o = mstatus_ret;
         end
         REDIR: begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = target_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_23060077_trap_ctrl.sv
// tb/tb_ysyx_23060077_trap_ctrl.sv - scoreboard bench for ysyx_23060077_trap_ctrl
module tb_ysyx_23060077_trap_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        trap_valid_i = 1'b0;
   logic        trap_ready_o;
   logic        exc_illegal_i = 1'b0;
   logic        exc_ebreak_i = 1'b0;
   logic        exc_ecall_i = 1'b0;
   logic        mret_i = 1'b0;
   logic [31:0] exc_pc_i = '0;
   logic [31:0] exc_tval_i = '0;
   logic        irq_timer_i = 1'b0;
   logic [31:0] irq_pc_i = '0;
   logic [31:0] csr_mstatus_i = '0;
   logic [31:0] csr_mtvec_i = '0;
   logic [31:0] csr_mepc_i = '0;
   logic        csr_wr_en_o;
   logic [11:0] csr_wr_addr_o;
   logic [31:0] csr_wr_data_o;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;
   logic        redirect_ready_i = 1'b0;
   logic        busy_o;

   ysyx_23060077_trap_ctrl #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
      .clock(clock), .reset(reset),
      .trap_valid_i(trap_valid_i), .trap_ready_o(trap_ready_o),
      .exc_illegal_i(exc_illegal_i), .exc_ebreak_i(exc_ebreak_i),
      .exc_ecall_i(exc_ecall_i), .mret_i(mret_i),
      .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
      .irq_timer_i(irq_timer_i), .irq_pc_i(irq_pc_i),
      .csr_mstatus_i(csr_mstatus_i), .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
      .csr_wr_en_o(csr_wr_en_o), .csr_wr_addr_o(csr_wr_addr_o), .csr_wr_data_o(csr_wr_data_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
      .redirect_ready_i(redirect_ready_i), .busy_o(busy_o)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          is_redir;
      logic [11:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

`ifdef YSYX_23060077_TRAP_VECTORED_EN
   localparam logic [31:0] VEC_TIMER = 32'h8000_041C;
`else
   localparam logic [31:0] VEC_TIMER = 32'h8000_0400;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic push_csr(input logic [11:0] a, input logic [31:0] d);
      exp_t e;
      e.is_redir = 1'b0; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic push_redir(input logic [31:0] pc);
      exp_t e;
      e.is_redir = 1'b1; e.addr = '0; e.data = pc;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_event();
      trap_valid_i  = 1'b0;
      exc_illegal_i = 1'b0;
      exc_ebreak_i  = 1'b0;
      exc_ecall_i   = 1'b0;
      mret_i        = 1'b0;
      irq_timer_i   = 1'b0;
   endtask

   // Accept edge, then count cycles until redirect_valid_o; checks latency and return to idle.
   task automatic run_trap(input string tag, input int exp_lat);
      int cyc;
      step();
      clear_event();
      cyc = 1;
      while (!redirect_valid_o && cyc < 20) begin
         step();
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      step();
      chk({tag, "_idle"}, {31'd0, trap_ready_o}, 32'd1);
   endtask

   // Scoreboard: every CSR write and every redirect handshake must match the queue head.
   always @(negedge clock) begin
      if (!reset && (csr_wr_en_o || (redirect_valid_o && redirect_ready_i))) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_output observed_wr=%b observed_redir=%b expected=none",
                   csr_wr_en_o, redirect_valid_o);
         end else begin
            e = exp_q.pop_front();
            if (csr_wr_en_o) begin
               chk("sb_kind_csr", {31'd0, e.is_redir}, 32'd0);
               chk("sb_csr_addr", {20'd0, csr_wr_addr_o}, {20'd0, e.addr});
               chk("sb_csr_data", csr_wr_data_o, e.data);
               chk("sb_no_redir_during_wr", {31'd0, redirect_valid_o}, 32'd0);
            end else begin
               chk("sb_kind_redir", {31'd0, e.is_redir}, 32'd1);
               chk("sb_redir_pc", redirect_pc_o, e.data);
            end
         end
      end
   end

   initial begin
      // Reset state
      #2;
      chk("rst_ready", {31'd0, trap_ready_o}, 32'd1);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_wr_en", {31'd0, csr_wr_en_o}, 32'd0);
      chk("rst_redir_valid", {31'd0, redirect_valid_o}, 32'd0);
      chk("rst_redir_pc", redirect_pc_o, 32'd0);
      step();
      reset = 1'b0;
      step();

      // ecall: full trap sequence, redirect in cycle 5
      csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h8000_0400;
      exc_pc_i = 32'h8000_0100; exc_tval_i = 32'h0;
      redirect_ready_i = 1'b1;
      trap_valid_i = 1'b1; exc_ecall_i = 1'b1;
      push_csr(12'h341, 32'h8000_0100);
      push_csr(12'h342, 32'd11);
      push_csr(12'h343, 32'h0);
      push_csr(12'h300, 32'h0000_1880);
      push_redir(32'h8000_0400);
      run_trap("ecall", 5);

      // mret with redirect held off for 3 cycles
      csr_mepc_i = 32'h8000_0104; csr_mstatus_i = 32'h1880;
      redirect_ready_i = 1'b0;
      trap_valid_i = 1'b1; mret_i = 1'b1;
      push_csr(12'h300, 32'h0000_1888);
      push_redir(32'h8000_0104);
      step();
      clear_event();
      chk("mret_busy_c1", {31'd0, busy_o}, 32'd1);
      chk("mret_ready_c1", {31'd0, trap_ready_o}, 32'd0);
      step();
      chk("mret_redir_valid_c2", {31'd0, redirect_valid_o}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mret_hold_valid", {31'd0, redirect_valid_o}, 32'd1);
         chk("mret_hold_pc", redirect_pc_o, 32'h8000_0104);
         chk("mret_hold_no_wr", {31'd0, csr_wr_en_o}, 32'd0);
      end
      redirect_ready_i = 1'b1;
      step();
      chk("mret_idle", {31'd0, trap_ready_o}, 32'd1);

      // illegal + ecall in the same cycle: illegal wins
      csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h8000_0400;
      exc_pc_i = 32'h8000_0300; exc_tval_i = 32'hFFFF_FFFF;
      trap_valid_i = 1'b1; exc_illegal_i = 1'b1; exc_ecall_i = 1'b1;
      push_csr(12'h341, 32'h8000_0300);
      push_csr(12'h342, 32'd2);
      push_csr(12'h343, 32'hFFFF_FFFF);
      push_csr(12'h300, 32'h0000_1880);
      push_redir(32'h8000_0400);
      run_trap("illegal", 5);

      // valid with no event bits: consumed, nothing happens
      exc_tval_i = 32'h0;
      trap_valid_i = 1'b1;
      step();
      clear_event();
      chk("noop_busy", {31'd0, busy_o}, 32'd0);
      chk("noop_ready", {31'd0, trap_ready_o}, 32'd1);

      // timer interrupt with MIE=1
      csr_mstatus_i = 32'h8; irq_pc_i = 32'h8000_0200;
      irq_timer_i = 1'b1;
      push_csr(12'h341, 32'h8000_0200);
      push_csr(12'h342, 32'h8000_0007);
      push_csr(12'h343, 32'h0);
      push_csr(12'h300, 32'h0000_1880);
      push_redir(32'h8000_0400);
      run_trap("timer", 5);

      // timer with MIE=0: ignored
      csr_mstatus_i = 32'h0; irq_timer_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("irq_masked_ready", {31'd0, trap_ready_o}, 32'd1);
         chk("irq_masked_wr", {31'd0, csr_wr_en_o}, 32'd0);
      end
      irq_timer_i = 1'b0;

      // timer with vectored-mode mtvec
      csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h8000_0401; irq_pc_i = 32'h8000_0208;
      irq_timer_i = 1'b1;
      push_csr(12'h341, 32'h8000_0208);
      push_csr(12'h342, 32'h8000_0007);
      push_csr(12'h343, 32'h0);
      push_csr(12'h300, 32'h0000_1880);
      push_redir(VEC_TIMER);
      run_trap("timer_vec", 5);

      // ebreak with vectored mtvec: exceptions always go to base
      exc_pc_i = 32'h8000_0500;
      trap_valid_i = 1'b1; exc_ebreak_i = 1'b1;
      push_csr(12'h341, 32'h8000_0500);
      push_csr(12'h342, 32'd3);
      push_csr(12'h343, 32'h0);
      push_csr(12'h300, 32'h0000_1880);
      push_redir(32'h8000_0400);
      run_trap("ebreak_vec", 5);

      // reset asserted during W_MCAUSE aborts the sequence
      csr_mtvec_i = 32'h8000_0400; exc_pc_i = 32'h8000_0600;
      trap_valid_i = 1'b1; exc_ecall_i = 1'b1;
      push_csr(12'h341, 32'h8000_0600);
      step();
      clear_event();
      step();
      chk("pre_rst_wr_en", {31'd0, csr_wr_en_o}, 32'd1);
      chk("pre_rst_addr", {20'd0, csr_wr_addr_o}, 32'h342);
      reset = 1'b1;
      #1;
      chk("midrst_wr_en", {31'd0, csr_wr_en_o}, 32'd0);
      chk("midrst_redir", {31'd0, redirect_valid_o}, 32'd0);
      chk("midrst_ready", {31'd0, trap_ready_o}, 32'd1);
      chk("midrst_busy", {31'd0, busy_o}, 32'd0);
      step();
      reset = 1'b0;
      step();
      chk("midrst_queue_drained", 32'(exp_q.size()), 32'd0);

      // ecall after reset completes normally
      csr_mstatus_i = 32'h8; exc_pc_i = 32'h8000_0700;
      trap_valid_i = 1'b1; exc_ecall_i = 1'b1;
      push_csr(12'h341, 32'h8000_0700);
      push_csr(12'h342, 32'd11);
      push_csr(12'h343, 32'h0);
      push_csr(12'h300, 32'h0000_1880);
      push_redir(32'h8000_0400);
      run_trap("ecall_after_rst", 5);

      step();
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
